// File: rtl/id_stage_pipelined_pkg.sv
// Shared decode constants and the control bundle carried through the ID/EXE register.
package id_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_MEM = 4'b0010;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_EOR = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_ADC = 4'b0101;
    localparam logic [3:0] OPC_SBC = 4'b0110;
    localparam logic [3:0] OPC_TST = 4'b1000;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;
    localparam logic [3:0] OPC_MVN = 4'b1111;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 9'b0_0000_0000;

    // A store reads Rd as its second source so the value to write travels with the slot.
    function automatic logic is_store(input logic [31:0] ins);
        return (ins[27:26] == MODE_MEM) && (ins[20] == 1'b0);
    endfunction

endpackage

// File: rtl/id_stage_pipelined_cond_check.sv
// Combinational ARM condition-code evaluation against the {N,Z,C,V} flags.
module cond_check
    import id_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] sr,
    output logic       met
);

    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = sr;

    // Map the condition field to its flag predicate; the NV encoding never passes.
    always_comb begin
        met = 1'b0;
        case (cond)
            COND_EQ: met = z_s;
            COND_NE: met = ~z_s;
            COND_CS: met = c_s;
            COND_CC: met = ~c_s;
            COND_MI: met = n_s;
            COND_PL: met = ~n_s;
            COND_VS: met = v_s;
            COND_VC: met = ~v_s;
            COND_HI: met = c_s & ~z_s;
            COND_LS: met = ~c_s | z_s;
            COND_GE: met = (n_s == v_s);
            COND_LT: met = (n_s != v_s);
            COND_GT: met = ~z_s & (n_s == v_s);
            COND_LE: met = z_s | (n_s != v_s);
            COND_AL: met = 1'b1;
            default: met = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// Instruction decode stage: decode, register file, condition check and the elastic ID/EXE register.
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int WB_PORTS = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instruction,
    input  logic [31:0]                pc_in,
    input  logic [WB_PORTS-1:0]        wb_en,
    input  logic [WB_PORTS*4-1:0]      wb_dest,
    input  logic [WB_PORTS*DATA_W-1:0] wb_data,
    input  logic [3:0]                 sr,
    input  logic                       hazard,
    input  logic                       flush,
    output logic [3:0]                 src1,
    output logic [3:0]                 src2,
    output logic                       two_src,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       ex_wb_en,
    output logic                       ex_mem_r_en,
    output logic                       ex_mem_w_en,
    output logic                       ex_b,
    output logic                       ex_s,
    output logic [3:0]                 ex_exe_cmd,
    output logic [DATA_W-1:0]          ex_val_rn,
    output logic [DATA_W-1:0]          ex_val_rm,
    output logic                       ex_imm,
    output logic [11:0]                ex_shift_operand,
    output logic [23:0]                ex_signed_imm_24,
    output logic [3:0]                 ex_dest,
    output logic [31:0]                ex_pc
);

    localparam int REG_AW = $clog2(NUM_REGS);

    logic [1:0]        mode_s;
    logic [3:0]        opcode_s;
    logic              cond_met_s;
    logic              advance_s;
    logic              load_s;
    ctrl_t             ctrl_s;
    ctrl_t             ctrl_eff_s;
    logic [DATA_W-1:0] rf_s [NUM_REGS];
    logic [DATA_W-1:0] val_rn_s;
    logic [DATA_W-1:0] val_rm_s;

    logic              out_valid_r;
    ctrl_t             ctrl_r;
    logic [DATA_W-1:0] val_rn_r;
    logic [DATA_W-1:0] val_rm_r;
    logic              imm_r;
    logic [11:0]       shift_r;
    logic [23:0]       simm_r;
    logic [3:0]        dest_r;
    logic [31:0]       pc_r;

    assign mode_s   = instruction[27:26];
    assign opcode_s = instruction[24:21];
    assign src1     = instruction[19:16];
    assign src2     = is_store(instruction) ? instruction[15:12] : instruction[3:0];
    assign two_src  = ~instruction[25] | is_store(instruction);

    assign advance_s = out_ready | ~out_valid_r;
    assign load_s    = in_valid & ~hazard & ~flush;
    assign in_ready  = advance_s & ~hazard & ~flush;

    cond_check u_cond (
        .cond (instruction[31:28]),
        .sr   (sr),
        .met  (cond_met_s)
    );

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_rf
        logic [DATA_W-1:0] q_r;

        // One register; later ports overwrite earlier ones so the highest index wins.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_r <= {DATA_W{1'b0}};
            end else begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_en[p] && (wb_dest[p*REG_AW +: REG_AW] == REG_AW'(r))) begin
                        q_r <= wb_data[p*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign rf_s[r] = q_r;
    end

    // Read ports; with bypass a same-cycle write is forwarded, the highest port taking priority.
    always_comb begin
        val_rn_s = rf_s[src1];
        val_rm_s = rf_s[src2];
        for (int p = 0; p < WB_PORTS; p++) begin
            val_rn_s = ((BYPASS != 0) && wb_en[p] && (wb_dest[p*REG_AW +: REG_AW] == src1))
                       ? wb_data[p*DATA_W +: DATA_W] : val_rn_s;
            val_rm_s = ((BYPASS != 0) && wb_en[p] && (wb_dest[p*REG_AW +: REG_AW] == src2))
                       ? wb_data[p*DATA_W +: DATA_W] : val_rm_s;
        end
    end

    // Instruction decode into the control bundle; compares always update flags.
    always_comb begin
        ctrl_s = CTRL_NONE;
        case (mode_s)
            MODE_ALU: begin
                ctrl_s.s     = instruction[20];
                ctrl_s.wb_en = 1'b1;
                case (opcode_s)
                    OPC_MOV: ctrl_s.exe_cmd = EXE_MOV;
                    OPC_MVN: ctrl_s.exe_cmd = EXE_MVN;
                    OPC_ADD: ctrl_s.exe_cmd = EXE_ADD;
                    OPC_ADC: ctrl_s.exe_cmd = EXE_ADC;
                    OPC_SUB: ctrl_s.exe_cmd = EXE_SUB;
                    OPC_SBC: ctrl_s.exe_cmd = EXE_SBC;
                    OPC_AND: ctrl_s.exe_cmd = EXE_AND;
                    OPC_ORR: ctrl_s.exe_cmd = EXE_ORR;
                    OPC_EOR: ctrl_s.exe_cmd = EXE_EOR;
                    OPC_CMP: begin
                        ctrl_s.exe_cmd = EXE_CMP;
                        ctrl_s.wb_en   = 1'b0;
                        ctrl_s.s       = 1'b1;
                    end
                    OPC_TST: begin
                        ctrl_s.exe_cmd = EXE_TST;
                        ctrl_s.wb_en   = 1'b0;
                        ctrl_s.s       = 1'b1;
                    end
                    default: ctrl_s = CTRL_NONE;
                endcase
            end
            MODE_MEM: begin
                ctrl_s.exe_cmd  = EXE_MEM;
                ctrl_s.s        = instruction[20];
                ctrl_s.wb_en    = instruction[20];
                ctrl_s.mem_r_en = instruction[20];
                ctrl_s.mem_w_en = ~instruction[20];
            end
            MODE_BR:  ctrl_s.b = 1'b1;
            default:  ctrl_s = CTRL_NONE;
        endcase
    end

    // A failed condition still occupies a slot but performs no architectural action.
    always_comb begin
        ctrl_eff_s = CTRL_NONE;
        if (cond_met_s) begin
            ctrl_eff_s = ctrl_s;
        end else begin
            ctrl_eff_s = CTRL_NONE;
        end
    end

    // ID/EXE register: bubble on flush/empty/hazard, load on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || (advance_s && !load_s)) begin
            out_valid_r <= 1'b0;
            ctrl_r      <= CTRL_NONE;
            val_rn_r    <= {DATA_W{1'b0}};
            val_rm_r    <= {DATA_W{1'b0}};
            imm_r       <= 1'b0;
            shift_r     <= 12'h000;
            simm_r      <= 24'h00_0000;
            dest_r      <= 4'h0;
            pc_r        <= 32'h0000_0000;
        end else if (advance_s) begin
            out_valid_r <= 1'b1;
            ctrl_r      <= ctrl_eff_s;
            val_rn_r    <= val_rn_s;
            val_rm_r    <= val_rm_s;
            imm_r       <= instruction[25];
            shift_r     <= instruction[11:0];
            simm_r      <= instruction[23:0];
            dest_r      <= instruction[15:12];
            pc_r        <= pc_in;
        end
    end

    assign out_valid        = out_valid_r;
    assign ex_wb_en         = ctrl_r.wb_en;
    assign ex_mem_r_en      = ctrl_r.mem_r_en;
    assign ex_mem_w_en      = ctrl_r.mem_w_en;
    assign ex_b             = ctrl_r.b;
    assign ex_s             = ctrl_r.s;
    assign ex_exe_cmd       = ctrl_r.exe_cmd;
    assign ex_val_rn        = val_rn_r;
    assign ex_val_rm        = val_rm_r;
    assign ex_imm           = imm_r;
    assign ex_shift_operand = shift_r;
    assign ex_signed_imm_24 = simm_r;
    assign ex_dest          = dest_r;
    assign ex_pc            = pc_r;

endmodule
